// File: rtl/led_ctrl_pkg.sv
// Shared constants and helpers for the push-button LED controller.
// Optional feature macro: LED_CTRL_PRESS_CNT_EN (press counter output).
package led_ctrl_pkg;

   localparam logic KEY_PRESSED_LOW         = 1'b0;
   localparam logic KEY_RELEASED_LOW        = 1'b1;
   localparam int   DEFAULT_DEBOUNCE_CYCLES = 20;

   // Idle pin level when nobody is touching the button.
   function automatic logic released_level(input int key_active_low);
      return (key_active_low != 0) ? KEY_RELEASED_LOW : ~KEY_RELEASED_LOW;
   endfunction

endpackage

// File: rtl/led_ctrl_if.sv
// Pin-side bundle of the LED controller: raw key in, LED drive out.
// Optional feature macro: LED_CTRL_PRESS_CNT_EN adds the press_cnt status output.
interface led_ctrl_if;

   logic       key;
   logic       led;
`ifdef LED_CTRL_PRESS_CNT_EN
   logic [7:0] press_cnt;
`endif

   modport master (
      output key,
      input  led
`ifdef LED_CTRL_PRESS_CNT_EN
      , input press_cnt
`endif
   );

   modport slave (
      input  key,
      output led
`ifdef LED_CTRL_PRESS_CNT_EN
      , output press_cnt
`endif
   );

endinterface

// File: rtl/led_ctrl_key_debounce.sv
// Two-flop synchroniser plus persistence-count debouncer for a raw pushbutton.
// Emits the accepted key level and a one-cycle pulse on each accepted press.
module key_debounce
   import led_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int KEY_ACTIVE_LOW  = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_level,
   output logic press_pulse
);

   localparam logic                 RELEASED = released_level(KEY_ACTIVE_LOW);
   localparam int                   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             key_s1_q, key_s1_d;
   logic             key_s2_q, key_s2_d;
   logic             key_db_q, key_db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      key_s1_d    = key_raw;
      key_s2_d    = key_s1_q;
      key_db_d    = key_db_q;
      cnt_d       = cnt_q;
      press_pulse = 1'b0;
      if (key_s2_q == key_db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         key_db_d    = key_s2_q;
         cnt_d       = '0;
         press_pulse = (key_s2_q != RELEASED);
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_s1_q <= RELEASED;
         key_s2_q <= RELEASED;
         key_db_q <= RELEASED;
         cnt_q    <= '0;
      end else begin
         key_s1_q <= key_s1_d;
         key_s2_q <= key_s2_d;
         key_db_q <= key_db_d;
         cnt_q    <= cnt_d;
      end
   end

   assign key_level = key_db_q;

endmodule

// File: rtl/led_ctrl.sv
// Push-button LED controller: toggles the LED once per debounced press.
// Optional feature macro: LED_CTRL_PRESS_CNT_EN adds an 8-bit wrapping press counter.
module led_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int   KEY_ACTIVE_LOW  = 1,
   parameter logic LED_RST_VAL     = 1'b0
) (
   input logic        clk,
   input logic        rst,
   led_ctrl_if.slave  io
);

   localparam logic RELEASED = released_level(KEY_ACTIVE_LOW);

   logic key_level;
   logic press_pulse;
   logic press_evt;
   logic led_q, led_d;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
   ) u_key_debounce (
      .clk         (clk),
      .rst         (rst),
      .key_raw     (io.key),
      .key_level   (key_level),
      .press_pulse (press_pulse)
   );

   // On the pulse cycle the accepted level still reads released; it flips on this edge.
   assign press_evt = press_pulse & (key_level == RELEASED);

   always_comb begin
      led_d = led_q ^ press_evt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q <= LED_RST_VAL;
      end else begin
         led_q <= led_d;
      end
   end

   assign io.led = led_q;

`ifdef LED_CTRL_PRESS_CNT_EN
   logic [7:0] press_cnt_q, press_cnt_d;

   always_comb begin
      press_cnt_d = press_cnt_q;
      if (press_evt) begin
         press_cnt_d = press_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         press_cnt_q <= '0;
      end else begin
         press_cnt_q <= press_cnt_d;
      end
   end

   assign io.press_cnt = press_cnt_q;
`endif

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl (DEBOUNCE_CYCLES=4, active-low key, LED reset value 0).
// Segment table plus hand sequences; expected LED/press count queued per driven cycle.
module tb_led_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   led_ctrl_if bus ();

   led_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .KEY_ACTIVE_LOW  (1),
      .LED_RST_VAL     (1'b0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   // One table row: hold rst/key for 'cycles' edges; LED flips at edge 'tog_at' (0 = never).
   typedef struct {
      logic rst;
      logic key;
      int   cycles;
      int   tog_at;
   } seg_t;

   typedef struct {
      logic       led;
      logic [7:0] cnt;
      string      tag;
   } exp_t;

   seg_t       segs[$];
   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic       exp_led;
   logic [7:0] exp_cnt;

   task automatic add(input logic r, input logic k, input int n, input int t);
      seg_t s;
      s.rst = r; s.key = k; s.cycles = n; s.tog_at = t;
      segs.push_back(s);
   endtask

   task automatic step(input logic r, input logic k, input logic tog, input string tag);
      exp_t e;
      rst     = r;
      bus.key = k;
      if (r) begin
         exp_led = 1'b0;
         exp_cnt = 8'd0;
      end else if (tog) begin
         exp_led = ~exp_led;
         exp_cnt = exp_cnt + 8'd1;
      end
      e.led = exp_led;
      e.cnt = exp_cnt;
      e.tag = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (bus.led !== e.led) begin
         n_fail++;
         $display("FAIL %s led: got %b, expected %b (t=%0t)", e.tag, bus.led, e.led, $time);
      end
`ifdef LED_CTRL_PRESS_CNT_EN
      n_checks++;
      if (bus.press_cnt !== e.cnt) begin
         n_fail++;
         $display("FAIL %s press_cnt: got %0d, expected %0d (t=%0t)", e.tag, bus.press_cnt, e.cnt, $time);
      end
`endif
   endtask

   initial begin
      rst     = 1'b1;
      bus.key = 1'b0;
      exp_led = 1'b0;
      exp_cnt = 8'd0;

      add(1'b1, 1'b0,  3, 0);   // reset with key already pressed
      add(1'b0, 1'b0, 10, 6);   // fresh press after reset
      add(1'b0, 1'b1, 10, 0);
      add(1'b0, 1'b0, 20, 6);   // clean press, held
      add(1'b0, 1'b1, 10, 0);   // release only
      for (int i = 0; i < 3; i++) begin
         add(1'b0, 1'b0, 2, 0);  // bounce
         add(1'b0, 1'b1, 2, 0);
      end
      add(1'b0, 1'b0, 12, 6);
      add(1'b0, 1'b1,  8, 0);
      for (int i = 0; i < 3; i++) begin
         add(1'b0, 1'b0, 8, 6);
         add(1'b0, 1'b1, 8, 0);
      end
      add(1'b0, 1'b0,  3, 0);   // mid-debounce reset
      add(1'b1, 1'b0,  1, 0);
      add(1'b0, 1'b0, 10, 6);

      foreach (segs[i]) begin
         for (int c = 1; c <= segs[i].cycles; c++) begin
            step(segs[i].rst, segs[i].key, logic'(segs[i].tog_at == c),
                 $sformatf("seg%0d.%0d", i, c));
         end
      end

      for (int c = 1; c <= 10; c++) step(1'b0, 1'b1, 1'b0, $sformatf("rel.%0d", c));
      // DEBOUNCE_CYCLES-1 pulse is rejected.
      for (int c = 1; c <= 3; c++) step(1'b0, 1'b0, 1'b0, $sformatf("short.%0d", c));
      for (int c = 1; c <= 8; c++) step(1'b0, 1'b1, 1'b0, $sformatf("short_rel.%0d", c));
      // DEBOUNCE_CYCLES pulse is accepted, toggling after the key is already back up.
      for (int c = 1; c <= 4; c++) step(1'b0, 1'b0, 1'b0, $sformatf("exact.%0d", c));
      step(1'b0, 1'b1, 1'b0, "exact_rel.1");
      step(1'b0, 1'b1, 1'b1, "exact_rel.2");
      for (int c = 3; c <= 10; c++) step(1'b0, 1'b1, 1'b0, $sformatf("exact_rel.%0d", c));

      // 256 presses: press count wraps through 255 -> 0.
      for (int p = 0; p < 256; p++) begin
         for (int c = 1; c <= 8; c++) step(1'b0, 1'b0, logic'(c == 6), $sformatf("wrap%0d.p%0d", p, c));
         for (int c = 1; c <= 8; c++) step(1'b0, 1'b1, 1'b0, $sformatf("wrap%0d.r%0d", p, c));
      end

      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
